// File: rtl/pal576i_csync_generator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pal576i_csync_generator: free-running PAL 625i composite sync and markers   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module pal576i_csync_generator #(
  parameter int unsigned LINE_CLKS       = 864,
  parameter int unsigned HSYNC_CLKS      = 63,
  parameter int unsigned EQ_CLKS         = 32,
  parameter int unsigned BROAD_HIGH_CLKS = 63,
  parameter int unsigned ACTIVE_START    = 132,
  parameter int unsigned ACTIVE_CLKS     = 720
) (
  input  logic       sysClock,
  input  logic       nReset,
  input  logic       clockEnable,
  output logic       csync,
  output logic       hsync,
  output logic       vsync,
  output logic       isFieldOdd,
  output logic [9:0] lineNumber,
  output logic [9:0] sampleCount,
  output logic       activeVideo
);

  localparam logic [9:0] C_LINE_LAST   = 10'(LINE_CLKS - 1);
  localparam logic [9:0] C_HALF        = 10'(LINE_CLKS / 2);
  localparam logic [9:0] C_HSYNC       = 10'(HSYNC_CLKS);
  localparam logic [9:0] C_EQ          = 10'(EQ_CLKS);
  localparam logic [9:0] C_BROAD_LOW   = 10'(LINE_CLKS / 2 - BROAD_HIGH_CLKS);
  localparam logic [9:0] C_ACT_START   = 10'(ACTIVE_START);
  localparam logic [9:0] C_ACT_END     = 10'(ACTIVE_START + ACTIVE_CLKS);

  generate
    if ((LINE_CLKS % 2 != 0) || (LINE_CLKS < 4) || (LINE_CLKS > 1022) ||
        (ACTIVE_START + ACTIVE_CLKS > LINE_CLKS) ||
        (HSYNC_CLKS > LINE_CLKS / 2) || (EQ_CLKS > LINE_CLKS / 2) ||
        (BROAD_HIGH_CLKS > LINE_CLKS / 2)) begin : g_param_error
      $error("pal576i_csync_generator: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_HSYNC = 2'd1,
    K_EQ    = 2'd2,
    K_BROAD = 2'd3
  } pulse_e;

  // Pulse shape for each half of a line across both fields of the frame.
  function automatic pulse_e pulse_kind(input logic [9:0] line, input logic second);
    pulse_e k;
    k = K_NONE;
    if (!second) begin
      if (line <= 10'd3 || line == 10'd314 || line == 10'd315)
        k = K_BROAD;
      else if (line <= 10'd5 || (line >= 10'd311 && line <= 10'd318) || line >= 10'd624)
        k = K_EQ;
      else
        k = K_HSYNC;
    end else begin
      if (line <= 10'd2 || (line >= 10'd313 && line <= 10'd315))
        k = K_BROAD;
      else if (line <= 10'd5 || line == 10'd311 || line == 10'd312 ||
               line == 10'd316 || line == 10'd317 || line >= 10'd623)
        k = K_EQ;
      else
        k = K_NONE;
    end
    return k;
  endfunction

  logic [9:0] samp_q, samp_d;
  logic [9:0] line_q, line_d;
  logic       csync_q, csync_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       odd_q, odd_d;
  logic       active_q, active_d;

  logic       w_second;
  logic [9:0] w_offset;
  logic       w_low;
  logic       w_start_odd;
  logic       w_start_even;
  pulse_e     w_kind;

  // Outputs are decoded from the next counter state so they register together.
  always_comb begin
    samp_d = samp_q;
    line_d = line_q;
    if (samp_q == C_LINE_LAST) begin
      samp_d = 10'd0;
      line_d = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
    end else begin
      samp_d = samp_q + 10'd1;
    end

    w_second = (samp_d >= C_HALF);
    w_offset = w_second ? (samp_d - C_HALF) : samp_d;
    w_kind   = pulse_kind(line_d, w_second);
    w_low    = 1'b0;
    case (w_kind)
      K_HSYNC: w_low = (w_offset < C_HSYNC);
      K_EQ:    w_low = (w_offset < C_EQ);
      K_BROAD: w_low = (w_offset < C_BROAD_LOW);
      default: w_low = 1'b0;
    endcase
    csync_d = ~w_low;

    w_start_odd  = (line_d == 10'd1) && (samp_d == 10'd0);
    w_start_even = (line_d == 10'd313) && (samp_d == C_HALF);
    hsync_d      = (samp_d == 10'd0);
    vsync_d      = w_start_odd || w_start_even;
    odd_d        = w_start_odd ? 1'b1 : (w_start_even ? 1'b0 : odd_q);

    active_d = (((line_d >= 10'd23) && (line_d <= 10'd310)) ||
                ((line_d >= 10'd336) && (line_d <= 10'd622))) &&
               (samp_d >= C_ACT_START) && (samp_d < C_ACT_END);
  end

  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      samp_q   <= 10'd0;
      line_q   <= 10'd1;
      csync_q  <= 1'b1;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      odd_q    <= 1'b1;
      active_q <= 1'b0;
    end else if (clockEnable) begin
      samp_q   <= samp_d;
      line_q   <= line_d;
      csync_q  <= csync_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      odd_q    <= odd_d;
      active_q <= active_d;
    end else begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end
  end

  assign csync       = csync_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign isFieldOdd  = odd_q;
  assign lineNumber  = line_q;
  assign sampleCount = samp_q;
  assign activeVideo = active_q;

endmodule
`default_nettype wire
